// File: rtl/opendap_ap_pkg.sv
// Shared constants and types for the opendap MEM-AP: register map, CSW encodings
// and the bus-access state type.
package opendap_ap_pkg;

    localparam logic [5:0] AP_ADDR_CSW = 6'h00;
    localparam logic [5:0] AP_ADDR_TAR = 6'h01;
    localparam logic [5:0] AP_ADDR_DRW = 6'h03;
    localparam logic [5:0] AP_ADDR_BD0 = 6'h04;
    localparam logic [5:0] AP_ADDR_IDR = 6'h3F;

    localparam logic [2:0] SIZE_BYTE = 3'b000;
    localparam logic [2:0] SIZE_HALF = 3'b001;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam logic [1:0] ADDRINC_OFF    = 2'b00;
    localparam logic [1:0] ADDRINC_SINGLE = 2'b01;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_BUSREQ = 1'b1
    } ap_state_e;

    // Unsupported transfer sizes collapse to word.
    function automatic logic [2:0] csw_size_legal(input logic [2:0] size);
        logic [2:0] res;
        case (size)
            SIZE_BYTE: res = SIZE_BYTE;
            SIZE_HALF: res = SIZE_HALF;
            default:   res = SIZE_WORD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/opendap_ap_tar_inc.sv
// Combinational TAR auto-increment: step of 1/2/4 bytes added to the low
// TAR_WRAP_BITS only, so the upper address bits never carry.
module opendap_ap_tar_inc
    import opendap_ap_pkg::*;
#(
    parameter int TAR_WRAP_BITS = 10
) (
    input  logic [31:0] tar,
    input  logic [2:0]  size,
    output logic [31:0] tar_next
);

    logic [TAR_WRAP_BITS-1:0] step_s;
    logic [TAR_WRAP_BITS-1:0] low_s;

    // Select step from transfer size and add within the wrap window.
    always_comb begin
        step_s = TAR_WRAP_BITS'(32'd4);
        case (size)
            SIZE_BYTE: step_s = TAR_WRAP_BITS'(32'd1);
            SIZE_HALF: step_s = TAR_WRAP_BITS'(32'd2);
            default:   step_s = TAR_WRAP_BITS'(32'd4);
        endcase
        low_s    = tar[TAR_WRAP_BITS-1:0] + step_s;
        tar_next = {tar[31:TAR_WRAP_BITS], low_s};
    end

endmodule

// File: rtl/opendap_mem_ap_lite.sv
// Minimal MEM-AP: CSW/TAR/IDR held locally, DRW/BDn turned into a single
// outstanding request/ack bus transfer, all in the swclk domain.
module opendap_mem_ap_lite
    import opendap_ap_pkg::*;
#(
    parameter logic [7:0]  AP_SEL        = 8'h00,
    parameter logic [31:0] IDR           = 32'h04770001,
    parameter int          TAR_WRAP_BITS = 10
) (
    input  logic        swclk,
    input  logic        rst_n,
    input  logic [7:0]  ap_sel,
    input  logic [5:0]  ap_addr,
    input  logic [31:0] ap_wdata,
    input  logic        ap_wen,
    input  logic        ap_ren,
    input  logic        ap_abort,
    output logic [31:0] ap_rdata,
    output logic        ap_rdy,
    output logic        ap_err,
    output logic        bus_req,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    ap_state_e   state_r, state_next_s;
    logic [2:0]  csw_size_r;
    logic [1:0]  csw_inc_r;
    logic [31:0] tar_r;
    logic        drw_r;
    logic        read_r;

    logic        is_drw_s, is_bd_s, sel_match_s, strobe_s;
    logic        start_bus_s, complete_s, local_wr_s, local_rd_s, unsel_s;
    logic [31:0] local_rdata_s, bus_addr_s, tar_inc_s;

    opendap_ap_tar_inc #(.TAR_WRAP_BITS(TAR_WRAP_BITS)) u_tar_inc (
        .tar      (tar_r),
        .size     (csw_size_r),
        .tar_next (tar_inc_s)
    );

    // Decode strobes and compute next state; abort overrides everything.
    always_comb begin
        state_next_s = state_r;
        start_bus_s  = 1'b0;
        complete_s   = 1'b0;
        local_wr_s   = 1'b0;
        local_rd_s   = 1'b0;
        unsel_s      = 1'b0;
        is_drw_s     = (ap_addr == AP_ADDR_DRW);
        is_bd_s      = (ap_addr[5:2] == AP_ADDR_BD0[5:2]);
        sel_match_s  = (ap_sel == AP_SEL);
        strobe_s     = ap_wen | ap_ren;
        if (ap_abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (strobe_s && !sel_match_s) begin
                        unsel_s = 1'b1;
                    end else if (strobe_s && (is_drw_s || is_bd_s)) begin
                        start_bus_s  = 1'b1;
                        state_next_s = ST_BUSREQ;
                    end else if (ap_wen) begin
                        local_wr_s = 1'b1;
                    end else if (ap_ren) begin
                        local_rd_s = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_BUSREQ: begin
                    if (bus_ack) begin
                        complete_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_BUSREQ;
                    end
                end
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Local register read mux and bus address formation.
    always_comb begin
        local_rdata_s = 32'h0000_0000;
        case (ap_addr)
            AP_ADDR_CSW: local_rdata_s = {24'h00_0000, (state_r == ST_BUSREQ), 1'b1,
                                          csw_inc_r, 1'b0, csw_size_r};
            AP_ADDR_TAR: local_rdata_s = tar_r;
            AP_ADDR_IDR: local_rdata_s = IDR;
            default:     local_rdata_s = 32'h0000_0000;
        endcase
        if (is_drw_s) begin
            bus_addr_s = tar_r;
        end else begin
            bus_addr_s = {tar_r[31:4], ap_addr[1:0], 2'b00};
        end
    end

    // FSM state register.
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // AP registers, bus request and DP-facing response.
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            ap_rdata   <= 32'h0000_0000;
            ap_rdy     <= 1'b1;
            ap_err     <= 1'b0;
            bus_req    <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= 32'h0000_0000;
            bus_size   <= 2'b10;
            bus_wdata  <= 32'h0000_0000;
            csw_size_r <= SIZE_WORD;
            csw_inc_r  <= ADDRINC_OFF;
            tar_r      <= 32'h0000_0000;
            drw_r      <= 1'b0;
            read_r     <= 1'b0;
        end else if (ap_abort) begin
            bus_req <= 1'b0;
            ap_rdy  <= 1'b1;
            ap_err  <= 1'b0;
        end else if (start_bus_s) begin
            ap_rdy    <= 1'b0;
            ap_err    <= 1'b0;
            bus_req   <= 1'b1;
            bus_write <= ap_wen;
            bus_addr  <= bus_addr_s;
            bus_size  <= is_drw_s ? csw_size_r[1:0] : SIZE_WORD[1:0];
            bus_wdata <= ap_wdata;
            drw_r     <= is_drw_s;
            read_r    <= ~ap_wen;
        end else if (complete_s) begin
            bus_req <= 1'b0;
            ap_rdy  <= 1'b1;
            ap_err  <= bus_err;
            if (read_r) begin
                ap_rdata <= bus_err ? 32'h0000_0000 : bus_rdata;
            end
            // Only an error-free DRW walks TAR; BDn addresses are TAR-relative.
            if (drw_r && !bus_err && (csw_inc_r == ADDRINC_SINGLE)) begin
                tar_r <= tar_inc_s;
            end
        end else if (local_wr_s) begin
            if (ap_addr == AP_ADDR_CSW) begin
                csw_size_r <= csw_size_legal(ap_wdata[2:0]);
                csw_inc_r  <= ap_wdata[5:4];
            end else if (ap_addr == AP_ADDR_TAR) begin
                tar_r <= ap_wdata;
            end
        end else if (local_rd_s) begin
            ap_rdata <= local_rdata_s;
        end else if (unsel_s) begin
            ap_rdata <= 32'h0000_0000;
            ap_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_opendap_mem_ap_lite.sv
// Self-checking bench for opendap_mem_ap_lite: transaction-level model of the AP
// plus a per-cycle compare of every DUT output against the model's expectation.
module tb_opendap_mem_ap_lite;

    logic        swclk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  ap_sel = 8'h00;
    logic [5:0]  ap_addr = 6'h00;
    logic [31:0] ap_wdata = 32'h0;
    logic        ap_wen = 1'b0, ap_ren = 1'b0, ap_abort = 1'b0;
    logic [31:0] ap_rdata;
    logic        ap_rdy, ap_err;
    logic        bus_req, bus_write;
    logic [31:0] bus_addr, bus_wdata;
    logic [1:0]  bus_size;
    logic        bus_ack = 1'b0, bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    opendap_mem_ap_lite dut (
        .swclk(swclk), .rst_n(rst_n), .ap_sel(ap_sel), .ap_addr(ap_addr),
        .ap_wdata(ap_wdata), .ap_wen(ap_wen), .ap_ren(ap_ren), .ap_abort(ap_abort),
        .ap_rdata(ap_rdata), .ap_rdy(ap_rdy), .ap_err(ap_err), .bus_req(bus_req),
        .bus_write(bus_write), .bus_addr(bus_addr), .bus_size(bus_size),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 swclk = ~swclk;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_low_cnt = 0;
    logic chk_en = 1'b0;

    // Model: architectural AP state and expected outputs.
    logic [31:0] m_tar;
    logic [2:0]  m_size;
    logic [1:0]  m_inc;
    logic [31:0] exp_rdata, exp_addr, exp_wdata;
    logic        exp_rdy, exp_err, exp_req, exp_write;
    logic [1:0]  exp_size;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            if (n_errors < 40)
                $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        m_tar = 32'h0; m_size = 3'd2; m_inc = 2'd0;
        exp_rdata = 32'h0; exp_rdy = 1'b1; exp_err = 1'b0; exp_req = 1'b0;
        exp_write = 1'b0; exp_addr = 32'h0; exp_size = 2'd2; exp_wdata = 32'h0;
    endtask

    function automatic logic [31:0] model_read(input logic [5:0] a);
        case (a)
            6'h00:   return 32'h40 | (32'(m_inc) << 4) | 32'(m_size);
            6'h01:   return m_tar;
            6'h3F:   return 32'h04770001;
            default: return 32'h0;
        endcase
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge swclk) begin
        if (!ap_rdy) rdy_low_cnt++;
        if (chk_en) begin
            cmp("ap_rdata", ap_rdata, exp_rdata);
            cmp("ap_rdy", 32'(ap_rdy), 32'(exp_rdy));
            cmp("ap_err", 32'(ap_err), 32'(exp_err));
            cmp("bus_req", 32'(bus_req), 32'(exp_req));
            if (exp_req) begin
                cmp("bus_write", 32'(bus_write), 32'(exp_write));
                cmp("bus_addr", bus_addr, exp_addr);
                cmp("bus_size", 32'(bus_size), 32'(exp_size));
                cmp("bus_wdata", bus_wdata, exp_wdata);
            end
        end
    end

    // One DP access. Called and returns at 1 time unit after a rising edge.
    // nwait: BUSREQ cycle carrying bus_ack; abort_at: BUSREQ cycle with abort (0 = none);
    // poke: try a CSW write while busy; abort_now: abort together with the strobe.
    task automatic do_access(input logic [7:0] sel, input logic [5:0] addr,
                             input logic [31:0] wdata, input logic wr, input int nwait,
                             input logic [31:0] rdat, input logic berr, input int abort_at,
                             input logic poke, input logic abort_now);
        logic        is_bus;
        logic [31:0] a;
        ap_sel = sel; ap_addr = addr; ap_wdata = wdata;
        ap_wen = wr; ap_ren = !wr; ap_abort = abort_now;
        @(posedge swclk); #1;
        ap_wen = 1'b0; ap_ren = 1'b0; ap_abort = 1'b0;
        if (abort_now) begin
            exp_req = 1'b0; exp_rdy = 1'b1; exp_err = 1'b0;
            return;
        end
        if (sel != 8'h00) begin
            exp_rdata = 32'h0; exp_err = 1'b0;
            return;
        end
        is_bus = (addr == 6'h03) || (addr >= 6'h04 && addr <= 6'h07);
        if (!is_bus) begin
            if (!wr) exp_rdata = model_read(addr);
            else if (addr == 6'h00) begin
                m_size = (wdata[2:0] > 3'd2) ? 3'd2 : wdata[2:0];
                m_inc  = wdata[5:4];
            end else if (addr == 6'h01) m_tar = wdata;
            return;
        end
        a = (addr == 6'h03) ? m_tar : ((m_tar & 32'hFFFF_FFF0) | (32'(addr - 6'h04) * 4));
        exp_req = 1'b1; exp_write = wr; exp_addr = a; exp_wdata = wdata;
        exp_size = (addr == 6'h03) ? m_size[1:0] : 2'd2;
        exp_rdy = 1'b0; exp_err = 1'b0;
        for (int i = 1; i <= nwait; i++) begin
            if (i == nwait) begin bus_ack = 1'b1; bus_rdata = rdat; bus_err = berr; end
            if (i == abort_at) ap_abort = 1'b1;
            if (poke && i < nwait) begin
                ap_addr = 6'h00; ap_wen = 1'b1; ap_wdata = $urandom;
            end
            @(posedge swclk); #1;
            bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
            ap_abort = 1'b0; ap_wen = 1'b0;
            if (i == abort_at) begin
                exp_req = 1'b0; exp_rdy = 1'b1; exp_err = 1'b0;
                return;
            end
        end
        exp_req = 1'b0; exp_rdy = 1'b1; exp_err = berr;
        if (!wr) exp_rdata = berr ? 32'h0 : rdat;
        if (addr == 6'h03 && !berr && m_inc == 2'd1)
            m_tar = (m_tar & 32'hFFFF_FC00) | ((m_tar + (32'd1 << m_size)) & 32'h0000_03FF);
    endtask

    task automatic rd(input logic [5:0] a);
        do_access(8'h00, a, $urandom, 1'b0, 1, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic wr_reg(input logic [5:0] a, input logic [31:0] d);
        do_access(8'h00, a, d, 1'b1, 1, 32'h0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #2 chk_en = 1'b1;
        cmp("reset_rdy", 32'(ap_rdy), 32'h1);
        cmp("reset_size", 32'(bus_size), 32'h2);
        @(posedge swclk); @(posedge swclk); #1 rst_n = 1'b1;

        rdy_low_cnt = 0;
        rd(6'h3F);
        cmp("idr_lit", ap_rdata, 32'h04770001);
        rd(6'h00);
        cmp("csw_reset_lit", ap_rdata, 32'h00000042);
        cmp("local_rdy_never_low", 32'(rdy_low_cnt), 32'h0);

        wr_reg(6'h00, 32'h12);
        wr_reg(6'h01, 32'h2000_0000);
        rdy_low_cnt = 0;
        do_access(8'h00, 6'h03, 32'hCAFEF00D, 1'b1, 3, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        cmp("drw_wr_addr_lit", bus_addr, 32'h2000_0000);
        cmp("drw_wr_wdata_lit", bus_wdata, 32'hCAFEF00D);
        cmp("drw_wr_rdy_low", 32'(rdy_low_cnt), 32'd3);
        rd(6'h01);
        cmp("tar_inc_word_lit", ap_rdata, 32'h2000_0004);

        wr_reg(6'h00, 32'h10);
        wr_reg(6'h01, 32'h1000_03FF);
        rdy_low_cnt = 0;
        do_access(8'h00, 6'h03, 32'h0, 1'b0, 1, 32'h0000_00A5, 1'b0, 0, 1'b0, 1'b0);
        cmp("drw_rd_lit", ap_rdata, 32'h0000_00A5);
        cmp("zero_wait_rdy_low", 32'(rdy_low_cnt), 32'd1);
        rd(6'h01);
        cmp("tar_wrap_lit", ap_rdata, 32'h1000_0000);

        do_access(8'h00, 6'h03, 32'h0, 1'b0, 2, 32'h1234_5678, 1'b1, 0, 1'b0, 1'b0);
        cmp("err_flag_lit", 32'(ap_err), 32'h1);
        cmp("err_rdata_lit", ap_rdata, 32'h0);
        rd(6'h01);
        cmp("tar_err_lit", ap_rdata, 32'h1000_0000);
        do_access(8'h00, 6'h03, 32'h55, 1'b1, 1, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        cmp("err_clear_lit", 32'(ap_err), 32'h0);

        wr_reg(6'h01, 32'h4000_0010);
        do_access(8'h00, 6'h06, 32'h0, 1'b0, 2, 32'hBEEF_0002, 1'b0, 0, 1'b1, 1'b0);
        cmp("bd2_addr_lit", bus_addr, 32'h4000_0018);
        cmp("bd2_size_lit", 32'(bus_size), 32'h2);
        rd(6'h01);
        cmp("bd_tar_lit", ap_rdata, 32'h4000_0010);
        rd(6'h00);
        cmp("busy_poke_csw_lit", ap_rdata, 32'h0000_0050);

        do_access(8'h00, 6'h03, 32'h0, 1'b0, 6, 32'h0, 1'b0, 3, 1'b0, 1'b0);
        cmp("abort_req_lit", 32'(bus_req), 32'h0);
        cmp("abort_rdy_lit", 32'(ap_rdy), 32'h1);
        do_access(8'h00, 6'h03, 32'h0, 1'b0, 2, 32'h9999_9999, 1'b0, 2, 1'b0, 1'b0);
        rd(6'h01);
        cmp("abort_tar_lit", ap_rdata, 32'h4000_0010);
        do_access(8'h01, 6'h3F, 32'h0, 1'b0, 1, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        cmp("unsel_rdata_lit", ap_rdata, 32'h0);
        do_access(8'h00, 6'h03, 32'h0, 1'b1, 1, 32'h0, 1'b0, 0, 1'b0, 1'b1);
        cmp("abort_strobe_lit", 32'(bus_req), 32'h0);
        wr_reg(6'h00, 32'h35);
        rd(6'h00);
        cmp("csw_size_clamp_lit", ap_rdata, 32'h0000_0072);

        for (int n = 0; n < 400; n++) begin
            logic [5:0] a;
            int         nw, ab;
            case ($urandom_range(0, 8))
                0: a = 6'h00; 1: a = 6'h01; 2, 3: a = 6'h03; 4: a = 6'h04;
                5: a = 6'(6'h05 + 6'($urandom_range(0, 2))); 6: a = 6'h3F;
                7: a = 6'h02; default: a = 6'h10;
            endcase
            nw = $urandom_range(1, 4);
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, nw) : 0;
            do_access(($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00, a,
                      (a == 6'h01 && $urandom_range(0, 1) == 1) ? 32'h0000_03F0 | $urandom_range(0, 15) : $urandom,
                      1'($urandom_range(0, 1)), nw, $urandom,
                      ($urandom_range(0, 7) == 0), ab, ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 19) == 0));
        end

        chk_en = 1'b0;
        ap_sel = 8'h00; ap_addr = 6'h03; ap_wen = 1'b1;
        @(posedge swclk); #1 ap_wen = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        cmp("async_rst_req", 32'(bus_req), 32'h0);
        cmp("async_rst_rdy", 32'(ap_rdy), 32'h1);
        @(posedge swclk); #1 rst_n = 1'b1;
        rd(6'h00);
        cmp("post_rst_csw_lit", ap_rdata, 32'h00000042);
        rd(6'h01);
        cmp("post_rst_tar_lit", ap_rdata, 32'h0);

        @(posedge swclk); #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/opendap_mem_ap_lite.md
Name: opendap_mem_ap_lite

Overview:
- Minimal ADIv5-style MEM-AP that sits directly downstream of opendap_sw_dp.
- Consumes the DP's AP request interface (sel/addr/wdata/wen/ren/abort) and returns rdata/rdy/err.
- Translates DRW/BDn accesses into a simple single-outstanding bus-master handshake toward target memory.
- Runs entirely in the swclk domain, so the FPGA example top can replace its tied-off AP signals with this block.

Parameters:
- AP_SEL, 8'h00, ap_sel value this AP responds to.
- IDR, 32'h04770001, value returned by IDR reads.
- TAR_WRAP_BITS, 10, TAR auto-increment carries only within this many LSBs (1 KiB).

Ports:
- swclk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- ap_sel  in  8  AP select from DP.
- ap_addr  in  6  AP register address bits [7:2].
- ap_wdata  in  32  write data.
- ap_wen  in  1  one-cycle write strobe.
- ap_ren  in  1  one-cycle read strobe.
- ap_abort  in  1  abort pulse from DP ABORT.DAPABORT.
- ap_rdata  out  32  read data, valid while ap_rdy high after a read.
- ap_rdy  out  1  high when idle or the access is complete.
- ap_err  out  1  the last completed access faulted.
- bus_req  out  1  bus request, held until bus_ack.
- bus_write  out  1  1 = write.
- bus_addr  out  32  byte address.
- bus_size  out  2  0 = byte, 1 = half, 2 = word.
- bus_wdata  out  32  write data.
- bus_ack  in  1  transfer complete, one cycle.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_err  in  1  transfer fault, valid with bus_ack.

Behaviour:
- Reset values:
  - ap_rdata = 0, ap_rdy = 1, ap_err = 0.
  - bus_req = 0, bus_write = 0, bus_addr = 0, bus_size = 2, bus_wdata = 0.
  - CSW.Size = 3'b010, CSW.AddrInc = 2'b00, TAR = 0.
- Register map (ap_addr):
  - 6'h00 CSW: [2:0] Size, [5:4] AddrInc RW; [6] DeviceEn RO 1; [7] TrInProg RO = busy; other bits RAZ/WI.
  - 6'h01 TAR: RW, 32 bits.
  - 6'h03 DRW.
  - 6'h04..6'h07 BD0..BD3.
  - 6'h3F IDR: RO.
  - All other addresses: RAZ/WI, no error.
- Unselected AP (ap_sel != AP_SEL): strobe ignored, ap_rdata <= 0, ap_rdy stays 1, ap_err <= 0.
- CSW.Size write of 3..7 stores 3'b010. AddrInc 2'b10/2'b11 are treated as 2'b00 and read back as written.
- Local registers (CSW/TAR/IDR/RAZ):
  - Complete in the strobe cycle; ap_rdy never drops.
  - Read: ap_rdata is updated at the clock edge ending the strobe cycle.
  - Write: takes effect at that edge.
- FSM states: IDLE, BUSREQ.
  - IDLE -> BUSREQ on a selected DRW/BDn strobe. At that edge: ap_rdy <= 0, bus_req <= 1, bus_write = wen, bus_size = CSW.Size[1:0], bus_wdata = ap_wdata, ap_err <= 0.
  - DRW address = TAR. BDn address = {TAR[31:4], n[1:0], 2'b00}; BDn always uses word size.
  - BUSREQ -> IDLE on bus_ack. At that edge: bus_req <= 0, ap_rdy <= 1, ap_err <= bus_err. On a read, ap_rdata <= bus_rdata, or 0 if bus_err.
  - TAR increment applies on DRW completion without error when AddrInc = 01. The increment is 1/2/4 per Size, added to TAR[TAR_WRAP_BITS-1:0] only; upper bits are unchanged, so 0x3FC + 4 -> 0x000.
  - No TAR increment on BDn access or on error.
- Strobes while in BUSREQ are ignored, including writes to CSW/TAR; the DP must wait for ap_rdy.
- ap_abort in any state:
  - Next edge forces IDLE, bus_req <= 0, ap_rdy <= 1, ap_err <= 0. TAR and CSW are unchanged.
  - The bus side must treat bus_req falling without bus_ack as a cancel.
  - If bus_ack and ap_abort coincide, abort wins: no TAR increment, rdata unchanged.
- Abort and a strobe in the same cycle: abort wins and the strobe is dropped.
- rst_n assertion mid-access: all outputs return to reset values asynchronously.
- Latency: a DRW with zero-wait bus gives ap_rdy low for exactly 1 cycle (bus_ack in the first BUSREQ cycle).

Decomposition:
- Package opendap_ap_pkg holds:
  - Register address constants (AP_ADDR_CSW/TAR/DRW/BD0/IDR).
  - Size encodings (SIZE_BYTE/HALF/WORD).
  - AddrInc encodings.
  - FSM state typedef.
- One sub-module, opendap_ap_tar_inc: combinational wrapped TAR increment, parameterised by TAR_WRAP_BITS.

Test Plan:
- After reset: read IDR -> ap_rdata = 32'h04770001, ap_rdy never low. Read CSW -> 32'h00000042.
- Write CSW = 32'h12, TAR = 32'h2000_0000; DRW write 32'hCAFEF00D with ack after 3 cycles -> bus_addr 32'h2000_0000, bus_size 2, bus_write 1, ap_rdy low 3 cycles, TAR reads 32'h2000_0004.
- CSW Size = byte, AddrInc = 01, TAR = 32'h1000_03FF; DRW read with bus_rdata 32'hA5 -> ap_rdata 32'hA5, TAR = 32'h1000_0000 (wrap).
- DRW read with bus_err = 1 -> ap_err = 1, ap_rdata = 0, TAR unchanged. The next successful access clears ap_err.
- BD2 read with TAR = 32'h4000_0010 -> bus_addr 32'h4000_0018, bus_size 2, TAR unchanged.
- DRW held in BUSREQ with no ack, then ap_abort -> bus_req 0 and ap_rdy 1 next cycle, ap_err 0, TAR unchanged. A strobe with ap_sel = 8'h01 -> no bus_req, ap_rdata 0.
